// File: rtl/write_through_cache.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Ports: clk/rst, core side (addr, data_in, wr, re, enable -> data_out, stall),
// external word memory side (ext_addr, ext_data_out, ext_wr, ext_re <- ext_data_in, ext_ack).
module write_through_cache #(
    parameter int INDEX_BITS   = 5,
    parameter int CACHE_LINES  = 2**INDEX_BITS,
    parameter int BLOCK_OFFSET = 6,
    parameter int DATA_LENGTH  = 2**BLOCK_OFFSET,
    parameter int TAG_BITS     = 32-INDEX_BITS-BLOCK_OFFSET,
    parameter int STATUS_BITS  = 1,
    parameter int LINE_LENGTH  = TAG_BITS+DATA_LENGTH*8+STATUS_BITS,
    parameter int WORD_SIZE    = 32,
    parameter int WORD_BYTES   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 wr,
    input  logic                 re,
    input  logic                 enable,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 stall,
    output logic [31:0]          ext_addr,
    output logic [31:0]          ext_data_out,
    output logic                 ext_wr,
    output logic                 ext_re,
    input  logic [31:0]          ext_data_in,
    input  logic                 ext_ack
);

    localparam int WORDS     = DATA_LENGTH/WORD_BYTES;
    localparam int WORD_BITS = BLOCK_OFFSET-2;
    localparam int DATA_BITS = DATA_LENGTH*8;
    localparam int VALID_BIT = LINE_LENGTH-STATUS_BITS;

    typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

    state_t                 state_q, state_d;
    logic [29:0]            req_addr_q;
    logic [WORD_SIZE-1:0]   req_data_q;
    logic [WORD_BITS-1:0]   count_q;
    // Line layout: {status, tag, 16 data words}, word 0 in the low bits.
    logic [LINE_LENGTH-1:0] line_q [CACHE_LINES];

    logic [TAG_BITS-1:0]    live_tag, req_tag;
    logic [INDEX_BITS-1:0]  live_idx, req_idx;
    logic [WORD_BITS-1:0]   live_word, req_word;
    logic [LINE_LENGTH-1:0] live_line, req_line;
    logic                   hit, req_hit;
    logic                   unused_addr;

    assign unused_addr = ^addr[1:0];

    assign live_tag  = addr[31 -: TAG_BITS];
    assign live_idx  = addr[BLOCK_OFFSET +: INDEX_BITS];
    assign live_word = addr[2 +: WORD_BITS];
    assign live_line = line_q[live_idx];
    assign hit = enable & live_line[VALID_BIT]
               & (live_line[DATA_BITS +: TAG_BITS] == live_tag);

    // The latched request drives the external side so a
    // wandering core address cannot corrupt a fill or write.
    assign req_tag  = req_addr_q[29 -: TAG_BITS];
    assign req_idx  = req_addr_q[BLOCK_OFFSET-2 +: INDEX_BITS];
    assign req_word = req_addr_q[0 +: WORD_BITS];
    assign req_line = line_q[req_idx];
    assign req_hit  = req_line[VALID_BIT]
                    & (req_line[DATA_BITS +: TAG_BITS] == req_tag);

    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        data_out     = '0;
        ext_wr       = 1'b0;
        ext_re       = 1'b0;
        ext_addr     = '0;
        ext_data_out = '0;
        unique case (state_q)
            IDLE: begin
                if (enable && wr) begin
                    stall   = 1'b1;
                    state_d = WRITE;
                end else if (enable && re) begin
                    if (hit) begin
                        data_out = live_line[WORD_SIZE*int'(live_word) +: WORD_SIZE];
                    end else begin
                        stall   = 1'b1;
                        state_d = FILL;
                    end
                end
            end
            WRITE: begin
                stall        = 1'b1;
                ext_wr       = 1'b1;
                ext_addr     = {req_addr_q, 2'b00};
                ext_data_out = req_data_q;
                if (ext_ack) state_d = DONE;
            end
            FILL: begin
                stall    = 1'b1;
                ext_re   = 1'b1;
                ext_addr = {req_tag, req_idx, count_q, 2'b00};
                if (ext_ack && (&count_q)) state_d = IDLE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            req_addr_q <= '0;
            req_data_q <= '0;
            for (int i = 0; i < CACHE_LINES; i++) begin
                line_q[i][VALID_BIT] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && enable && (wr || re)) begin
                req_addr_q <= addr[31:2];
                req_data_q <= data_in;
            end
            // Invalidate up front so an aborted refill never leaves
            // an old tag paired with half-new data.
            if (state_q == IDLE && enable && !wr && re && !hit) begin
                line_q[live_idx][VALID_BIT] <= 1'b0;
            end
            if (state_q == WRITE && ext_ack && req_hit) begin
                line_q[req_idx][WORD_SIZE*int'(req_word) +: WORD_SIZE] <= req_data_q;
            end
            if (state_q == FILL && ext_ack) begin
                line_q[req_idx][WORD_SIZE*int'(count_q) +: WORD_SIZE] <= ext_data_in;
                count_q <= count_q + 1'b1;
                if (&count_q) begin
                    line_q[req_idx][DATA_BITS +: TAG_BITS] <= req_tag;
                    line_q[req_idx][VALID_BIT]             <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_write_through_cache.sv
// Directed bench for write_through_cache.
// Word memory responder acks every second strobe cycle.
module tb_write_through_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic        wr = 1'b0;
    logic        re = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] data_out;
    logic        stall;
    logic [31:0] ext_addr;
    logic [31:0] ext_data_out;
    logic        ext_wr;
    logic        ext_re;
    logic [31:0] ext_data_in = '0;
    logic        ext_ack = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log [$];
    logic [31:0] wr_log [$];
    logic        phase = 1'b0;

    write_through_cache dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .wr(wr), .re(re), .enable(enable),
        .data_out(data_out), .stall(stall),
        .ext_addr(ext_addr), .ext_data_out(ext_data_out),
        .ext_wr(ext_wr), .ext_re(ext_re),
        .ext_data_in(ext_data_in), .ext_ack(ext_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hD00D_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // External memory: ack on the second cycle of each strobe.
    always @(negedge clk) begin
        ext_ack = 1'b0;
        if (ext_re || ext_wr) begin
            if (phase) begin
                ext_ack = 1'b1;
                if (ext_re) begin
                    ext_data_in = mem_rd(ext_addr);
                    rd_log.push_back(ext_addr);
                end else begin
                    mem[ext_addr] = ext_data_out;
                    wr_log.push_back(ext_addr);
                end
            end
            phase = ~phase;
        end else begin
            phase = 1'b0;
        end
    end

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
    endtask

    // Called just after a posedge; returns on the cycle stall drops.
    task automatic wait_done(input logic [31:0] wa, input logic [31:0] wd,
                             output int cycles);
        bit done = 0;
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ext_wr) begin
                check("wr_addr", ext_addr, wa);
                check("wr_data", ext_data_out, wd);
            end
            if (!stall) begin
                done = 1;
                break;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!done) check("timeout", 32'd1, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output int cycles);
        addr = a; enable = 1'b1; re = 1'b1; wr = 1'b0;
        wait_done('0, '0, cycles);
        d = data_out;
        @(posedge clk);
        #1;
        re = 1'b0; enable = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] v,
                            output int cycles);
        addr = a; data_in = v; enable = 1'b1; wr = 1'b1; re = 1'b0;
        wait_done(a, v, cycles);
        @(posedge clk);
        #1;
        wr = 1'b0; enable = 1'b0;
    endtask

    logic [31:0] d;
    int          cyc;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_dout", data_out, 32'd0);
        check("rst_strobes", {30'd0, ext_wr, ext_re}, 32'd0);
        check("rst_eaddr", ext_addr, 32'd0);
        @(posedge clk);
        #1;

        // Write to an invalid line: no allocate.
        clear_logs();
        do_write(32'hF0, 32'hFFFF_FFFF, cyc);
        check("w1_cycles", cyc, 32'd3);
        check("w1_nwr", wr_log.size(), 32'd1);
        check("w1_nrd", rd_log.size(), 32'd0);
        @(negedge clk);
        check("w1_after_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;

        // Read miss on line 0.
        clear_logs();
        do_read(32'h1, d, cyc);
        check("r1_cycles", cyc, 32'd33);
        check("r1_data", d, 32'hD00D_0000);
        check("r1_nrd", rd_log.size(), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < rd_log.size()) check("r1_addr", rd_log[i], 32'(i*4));
        end

        // Read hit, same line.
        clear_logs();
        do_read(32'h4, d, cyc);
        check("r2_cycles", cyc, 32'd0);
        check("r2_data", d, 32'hD00D_0004);
        check("r2_nrd", rd_log.size(), 32'd0);

        // Line 3 must still be invalid after the earlier write.
        clear_logs();
        do_read(32'hF0, d, cyc);
        check("r3_cycles", cyc, 32'd33);
        check("r3_data", d, 32'hFFFF_FFFF);
        check("r3_nrd", rd_log.size(), 32'd16);
        if (rd_log.size() == 16) begin
            check("r3_first", rd_log[0], 32'hC0);
            check("r3_last", rd_log[15], 32'hFC);
        end

        // Write hit updates the cached word.
        clear_logs();
        do_write(32'hF0, 32'h1234_5678, cyc);
        check("w2_cycles", cyc, 32'd3);
        check("w2_nwr", wr_log.size(), 32'd1);
        clear_logs();
        do_read(32'hF0, d, cyc);
        check("r4_cycles", cyc, 32'd0);
        check("r4_data", d, 32'h1234_5678);
        check("r4_nrd", rd_log.size(), 32'd0);

        // Conflict miss on index 0.
        clear_logs();
        do_read(32'h800, d, cyc);
        check("r5_cycles", cyc, 32'd33);
        check("r5_data", d, 32'hD00D_0800);
        if (rd_log.size() == 16) begin
            check("r5_first", rd_log[0], 32'h800);
            check("r5_last", rd_log[15], 32'h83C);
        end else begin
            check("r5_nrd", rd_log.size(), 32'd16);
        end
        clear_logs();
        do_read(32'h0, d, cyc);
        check("r6_cycles", cyc, 32'd33);
        check("r6_data", d, 32'hD00D_0000);

        // Reset in the middle of a fill.
        addr = 32'h400; enable = 1'b1; re = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("mid_fill_re", {31'd0, ext_re}, 32'd1);
        rst = 1'b1; re = 1'b0; enable = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_strobes", {30'd0, ext_wr, ext_re}, 32'd0);
        check("rstmid_eaddr", ext_addr, 32'd0);
        check("rstmid_edata", ext_data_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_stall", {31'd0, stall}, 32'd0);
        check("rstmid_dout", data_out, 32'd0);
        @(posedge clk);
        #1;
        clear_logs();
        do_read(32'h400, d, cyc);
        check("r7_cycles", cyc, 32'd33);
        check("r7_nrd", rd_log.size(), 32'd16);
        check("r7_data", d, 32'hD00D_0400);

        // Valid bits were cleared: line 0 misses again.
        clear_logs();
        do_read(32'h4, d, cyc);
        check("r8_cycles", cyc, 32'd33);
        check("r8_data", d, 32'hD00D_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/write_through_cache.md
# write_through_cache

Direct-mapped, write-through, no-write-allocate data cache between a 32-bit core port and a word-wide external memory. Read hits return data combinationally. Read misses refill a full 64-byte line word by word. Every write goes to external memory, and `stall` holds the requester until the external access acknowledges.

## Interface
- `INDEX_BITS`, 5, line index width
- `CACHE_LINES`, 2**INDEX_BITS, number of lines
- `BLOCK_OFFSET`, 6, byte-offset bits within a line
- `DATA_LENGTH`, 2**BLOCK_OFFSET, line size in bytes
- `TAG_BITS`, 32-INDEX_BITS-BLOCK_OFFSET, tag width (21)
- `STATUS_BITS`, 1, per-line status (valid bit)
- `LINE_LENGTH`, TAG_BITS+DATA_LENGTH*8+STATUS_BITS, stored line width
- `WORD_SIZE`, 32, data word width
- `WORD_BYTES`, 4, bytes per word
- One clock; reset is synchronous and active-high. Ports `clk` and `rst`.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `addr` in 32: byte address; bits [1:0] are ignored.
- `data_in` in WORD_SIZE: write data.
- `wr` in 1: write request.
- `re` in 1: read request.
- `enable` in 1: request qualifier. `wr`/`re` are ignored when low.
- `data_out` out WORD_SIZE: read data.
- `stall` out 1: the request is not complete. The requester holds its request stable while this is high.
- `ext_addr` out 32: external word address, byte-aligned (bits [1:0]=0).
- `ext_data_out` out 32: external write data.
- `ext_wr` out 1: external write strobe.
- `ext_re` out 1: external read strobe.
- `ext_data_in` in 32: external read data.
- `ext_ack` in 1: external access complete. For reads, `ext_data_in` is valid in this cycle.

## Operation
- Address split: tag = `addr[31:11]`, index = `addr[10:6]`, word = `addr[5:2]`.
- Each line holds a valid bit, a tag, and 16 words. The line array is registered.
- Hit condition: `enable & valid[index] & tag match`.
- States: IDLE, WRITE, FILL, DONE.
- IDLE, `wr` (takes priority over `re`):
  - `stall`=1; go to WRITE.
  - Latch `addr` and `data_in`.
- IDLE, `re` hit: `stall`=0; `data_out` = selected word. Stay in IDLE.
- IDLE, `re` miss: `stall`=1; go to FILL with word counter = 0.
- IDLE, no request: `stall`=0; `data_out`=0.
- WRITE:
  - Drive `ext_wr`=1, `ext_addr`={addr[31:2],2'b00}, `ext_data_out`=data_in.
  - On `ext_ack`: if the line hits, update that word in the array. A miss does not allocate.
  - Then go to DONE.
- FILL:
  - Drive `ext_re`=1, `ext_addr`={tag,index,count,2'b00}.
  - On each `ext_ack`, store `ext_data_in` into word `count` and increment `count`.
  - After word 15: write tag, set valid, go to IDLE. The held read then hits.
- DONE: `stall`=0 for exactly one cycle, which retires the write. Next state IDLE.
- `stall` is high in WRITE and FILL.
- `ext_wr` and `ext_re` are never high together. Both are 0 in IDLE and DONE.
- `ext_ack` is ignored when neither strobe is high.

## Timing
- Read hit: zero latency. Combinational `data_out`, `stall`=0 in the request cycle.
- Read miss: 1 + 16 acknowledged external reads (N_ack cycles total), then IDLE returns the data with `stall`=0.
- Write: the request cycle plus WRITE cycles until ack, then one DONE cycle with `stall`=0.
- The counter wraps from 15 to 0 on fill completion.
- Reset at any time, including mid-FILL or mid-WRITE:
  - Next state IDLE.
  - All valid bits cleared.
  - `ext_wr`=`ext_re`=0, `ext_addr`=0, `ext_data_out`=0.
  - A partial fill is discarded.
- After reset, `stall`=0 and `data_out`=0 until a request arrives.

## Test plan
- Reset, then write `0xFFFFFFFF` to `0xF0`:
  - `ext_wr`=1 with `ext_addr`=`0xF0` and data `0xFFFFFFFF` until ack.
  - `stall`=1 through ack, then exactly one `stall`=0 cycle.
  - Line 3 stays invalid.
- After that write, read `0x1`:
  - Miss; 16 `ext_re` accesses at `0x00`–`0x3C`.
  - Then `stall`=0 and `data_out` = memory word 0.
- Read `0x4`: hit, `stall`=0 in the same cycle, `data_out` = memory word 1, no external access.
- Read `0xF0`: fill of line 3 (`0xC0`–`0xFC`), returns `0xFFFFFFFF`.
- Write `0x12345678` to `0xF0`: external write issued and the cached word updated. A subsequent read hits with `0x12345678`.
- Read `0x800` (index 0, tag 1) after line 0 is filled:
  - Conflict miss; refill from `0x800`–`0x83C`.
  - Then `0x0` misses again.
- Assert `rst` midway through a fill: strobes drop next cycle. A re-read of the same address performs a full 16-word fill.
